mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the instruction-cache and data-cache miss ports onto the single line-wide memory port of the out-of-order core. Sits between the two cache DFP interfaces and the backing memory adapter, carries one transaction at a time, and uses round-robin priority so that a stream of dcache misses cannot starve fetch, and the reverse. Responses are routed back to the owning cache as a one-cycle pulse with registered data.

## Interface
- LINE_WIDTH, 256, cache line width in bits
- ADDR_WIDTH, 32, byte address width; line offset is $clog2(LINE_WIDTH/8) bits
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_addr  in  ADDR_WIDTH  icache miss address
- i_read  in  1  icache line read request, held until i_resp
- i_rdata  out  LINE_WIDTH  line returned to icache, valid with i_resp
- i_resp  out  1  one-cycle icache completion pulse
- d_addr  in  ADDR_WIDTH  dcache miss or writeback address
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache line writeback request, held until d_resp
- d_wdata  in  LINE_WIDTH  writeback line
- d_rdata  out  LINE_WIDTH  line returned to dcache, valid with d_resp
- d_resp  out  1  one-cycle dcache completion pulse, for reads and for writes
- mem_addr  out  ADDR_WIDTH  line-aligned address: offset bits forced to 0
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_wdata  out  LINE_WIDTH  write line
- mem_ready  in  1  memory accepts the command this cycle
- mem_rdata  in  LINE_WIDTH  read line, valid with mem_resp
- mem_resp  in  1  read data valid, or write acknowledged

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- **IDLE**
  - Evaluates i_req = i_read and d_req = d_read | d_write.
  - One requester active: grant it.
  - Both active: grant the requester that is not last_grant.
  - On grant, latch owner, line-aligned address, op (write if d_write, else read) and wdata. Update last_grant. Go to ISSUE.
- **ISSUE**
  - Drive mem_read or mem_write, mem_addr and mem_wdata from the latched values.
  - On mem_ready: drop the command and go to WAIT.
- **WAIT**
  - On mem_resp: capture mem_rdata into the owner's rdata register (writes capture nothing) and go to RESP.
- **RESP**
  - Pulse the owner's resp for exactly one cycle; the other resp stays 0. Then go to IDLE.
- Requester rule: a cache drops read/write in the cycle after it sees resp. IDLE is therefore never reached with a stale request from the just-served owner.
- d_read and d_write both high is illegal. The write takes precedence, and a simulation assertion flags it.
- mem_resp outside WAIT and mem_ready outside ISSUE are ignored.
- i_rdata and d_rdata hold their last captured value until overwritten.
- Latched request fields are not re-sampled after the grant. Requester inputs changing mid-transaction have no effect.
- Reset, including mid-transaction:
  - state = IDLE; last_grant = dcache, so the icache wins the first tie.
  - All command and resp outputs = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - A mem_resp arriving after reset is ignored.

## Timing
- Request first high in IDLE at cycle t → mem_read/mem_write high from t+1.
- Command stays high through the mem_ready cycle r and is low from r+1.
- mem_resp at cycle w (w ≥ r+1) → resp pulse and rdata valid at cycle w+1. IDLE at w+2.
- Minimum occupancy: 4 cycles per transaction (mem_ready at t+1, mem_resp at t+2 → resp at t+3, next grant at t+4).
- Back-to-back contention alternates owners. A waiting requester is granted within one transaction of the other.
- Never more than one command outstanding. mem_read and mem_write are never high together.

## Test plan
- **Reset idle:** rst for 2 cycles with i_read=1.
  - All outputs are 0 during reset.
  - mem_read rises the cycle after rst falls, with mem_addr = i_addr & ~32'h1F.
- **Single icache read:** i_addr=32'h1ECEB004; mem_ready 2 cycles after issue; mem_resp 3 cycles later with rdata=256'hA5…A5.
  - mem_addr = 32'h1ECEB000.
  - i_resp is high for 1 cycle with i_rdata = A5…A5.
  - d_resp stays 0.
- **Simultaneous requests out of reset:** i_read=1 and d_read=1 in the same cycle.
  - Icache is served first, then dcache.
  - Repeat the pair: icache and dcache alternate (I, D, I, D).
- **Dcache writeback:** d_write=1, d_addr=32'h00001040, d_wdata=256'h1234.
  - mem_write=1 with mem_wdata=256'h1234.
  - d_resp pulses after mem_resp; d_rdata is unchanged.
- **Reset mid-WAIT:** assert rst while a read is in WAIT, then pulse mem_resp after reset.
  - No i_resp or d_resp is produced.
  - FSM is in IDLE.
- **Backpressure:** hold mem_ready=0 for 10 cycles.
  - mem_read and mem_addr stay stable throughout.
  - Exactly one command is accepted.

Source files
------------

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin icache/dcache miss arbiter onto one line memory port
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_read,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,

   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,

   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state;
   logic   last_grant;   // 1 = dcache was granted most recently
   logic   owner;        // 1 = dcache owns the current transaction
   logic   is_write;

   logic                  i_req;
   logic                  d_req;
   logic                  grant_d;
   logic [ADDR_WIDTH-1:0] sel_addr;

   assign i_req    = i_read;
   assign d_req    = d_read | d_write;
   // On a tie the side that did not win last time gets the port.
   assign grant_d  = d_req & (~i_req | ~last_grant);
   assign sel_addr = grant_d ? d_addr : i_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         is_write   <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_resp     <= 1'b0;
         d_resp     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req | d_req) begin
                  owner      <= grant_d;
                  last_grant <= grant_d;
                  is_write   <= grant_d & d_write;
                  mem_addr   <= sel_addr & LINE_MASK;
                  if (grant_d) begin
                     mem_wdata <= d_wdata;
                  end
                  mem_read   <= ~(grant_d & d_write);
                  mem_write  <= grant_d & d_write;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp) begin
                  if (!is_write) begin
                     if (owner) begin
                        d_rdata <= mem_rdata;
                     end else begin
                        i_rdata <= mem_rdata;
                     end
                  end
                  i_resp <= ~owner;
                  d_resp <= owner;
                  state  <= RESP;
               end
            end
            RESP: begin
               i_resp <= 1'b0;
               d_resp <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_no_read_and_write: assert property (@(posedge clk) disable iff (rst)
      !(d_read && d_write));

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : table-driven and randomized checks of mem_arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   logic         clk;
   logic         rst;
   logic [31:0]  i_addr;
   logic         i_read;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic [31:0]  d_addr;
   logic         d_read;
   logic         d_write;
   logic [255:0] d_wdata;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic [31:0]  mem_addr;
   logic         mem_read;
   logic         mem_write;
   logic [255:0] mem_wdata;
   logic         mem_ready;
   logic [255:0] mem_rdata;
   logic         mem_resp;

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .i_addr    (i_addr),
      .i_read    (i_read),
      .i_rdata   (i_rdata),
      .i_resp    (i_resp),
      .d_addr    (d_addr),
      .d_read    (d_read),
      .d_write   (d_write),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_resp    (d_resp),
      .mem_addr  (mem_addr),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // memory model
   bit           mem_auto;
   bit           noise;
   int           ready_lat;
   int           resp_lat;
   int           cmd_age;
   int           wait_cnt;
   bit           awaiting;
   bit           acc_write;
   logic [31:0]  acc_addr;
   int           n_accept;
   logic [255:0] mem_model [logic [31:0]];

   // reference of the arbiter's observable behaviour
   bit           last_owner;   // 1 = dcache
   bit           cur_owner;
   bit           tb_idle;
   bit           resp_seen;
   bit           resp_pend;
   bit           resp_owner;
   bit           resp_is_read;
   logic [255:0] resp_data;
   bit           exp_iresp;
   bit           exp_dresp;
   logic [255:0] exp_irdata;
   logic [255:0] exp_drdata;
   logic [31:0]  cur_iaddr;
   logic [31:0]  cur_daddr;
   bit           cur_dwr;
   logic [255:0] cur_dwdata;
   logic [31:0]  addr_log [$];

   function automatic logic [31:0] align(input logic [31:0] a);
      return {a[31:5], 5'b0};
   endfunction

   function automatic logic [255:0] rnd_line();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {8{a ^ 32'h5A5A_C3C3}};
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic req_i(input logic [31:0] a);
      i_addr    = a;
      cur_iaddr = a;
      i_read    = 1'b1;
   endtask

   task automatic req_d(input logic [31:0] a, input bit wr, input logic [255:0] wd);
      d_addr     = a;
      d_wdata    = wd;
      cur_daddr  = a;
      cur_dwr    = wr;
      cur_dwdata = wd;
      d_read     = !wr;
      d_write    = wr;
   endtask

   task automatic mem_step();
      mem_ready = 1'b0;
      mem_resp  = 1'b0;
      mem_rdata = rnd_line();
      if ((mem_read || mem_write) && !awaiting) begin
         cmd_age++;
         if (cmd_age > ready_lat) begin
            mem_ready = 1'b1;
            awaiting  = 1'b1;
            wait_cnt  = 0;
            cmd_age   = 0;
            acc_write = mem_write;
            acc_addr  = mem_addr;
            n_accept++;
            if (mem_write) mem_model[mem_addr] = mem_wdata;
         end
      end else if (awaiting) begin
         wait_cnt++;
         if (wait_cnt >= resp_lat) begin
            mem_resp     = 1'b1;
            awaiting     = 1'b0;
            if (!acc_write) mem_rdata = line_of(acc_addr);
            resp_pend    = 1'b1;
            resp_owner   = cur_owner;
            resp_is_read = !acc_write;
            resp_data    = mem_rdata;
         end
      end else if (noise) begin
         mem_ready = ($urandom_range(0, 7) == 0);
         mem_resp  = ($urandom_range(0, 7) == 0);
      end
   endtask

   // One clock: sample #1 after the edge, check against the reference, then
   // let the requesters and the memory model react for the next edge.
   task automatic tick();
      bit           p_rst, p_ireq, p_dreq, p_ready, p_rd, p_wr, p_idle, rose, eown;
      logic [31:0]  p_addr;
      logic [255:0] p_wdata;
      p_rst   = rst;
      p_ireq  = i_read;
      p_dreq  = d_read | d_write;
      p_ready = mem_ready;
      p_rd    = mem_read;
      p_wr    = mem_write;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_idle  = tb_idle;
      @(posedge clk);
      #1;
      if (p_rst) begin
         chk("rst_ctl", {mem_read, mem_write, i_resp, d_resp}, 0);
         chk("rst_addr", mem_addr, 0);
         chk("rst_wdata", mem_wdata, 0);
         chk("rst_irdata", i_rdata, 0);
         chk("rst_drdata", d_rdata, 0);
         tb_idle    = 1'b1;
         resp_seen  = 1'b0;
         resp_pend  = 1'b0;
         exp_irdata = '0;
         exp_drdata = '0;
         last_owner = 1'b1;
         awaiting   = 1'b0;
         cmd_age    = 0;
      end else begin
         chk("one_cmd", mem_read & mem_write, 0);
         if (p_rd || p_wr) begin
            if (p_ready) begin
               chk("cmd_drop", {mem_read, mem_write}, 0);
            end else begin
               chk("cmd_hold", {mem_read, mem_write}, {p_rd, p_wr});
               chk("addr_hold", mem_addr, p_addr);
               chk("wdata_hold", mem_wdata, p_wdata);
            end
         end
         rose = !(p_rd || p_wr) && (mem_read || mem_write);
         if (p_idle && (p_ireq || p_dreq)) chk("grant_latency", rose, 1);
         else chk("no_extra_cmd", rose, 0);
         if (rose) begin
            eown       = (p_ireq && p_dreq) ? !last_owner : p_dreq;
            last_owner = eown;
            cur_owner  = eown;
            tb_idle    = 1'b0;
            addr_log.push_back(mem_addr);
            if (!eown) begin
               chk("i_addr", mem_addr, align(cur_iaddr));
               chk("i_op", {mem_read, mem_write}, 2'b10);
               if (noise) i_addr = {4'h1, 28'($urandom)};
            end else begin
               chk("d_addr", mem_addr, align(cur_daddr));
               chk("d_op", {mem_read, mem_write}, cur_dwr ? 2'b01 : 2'b10);
               if (cur_dwr) chk("d_wdata", mem_wdata, cur_dwdata);
               if (noise) begin
                  d_addr  = {4'h2, 28'($urandom)};
                  d_wdata = rnd_line();
               end
            end
         end else if (resp_seen) begin
            tb_idle = 1'b1;
         end
         exp_iresp = resp_pend && !resp_owner;
         exp_dresp = resp_pend && resp_owner;
         if (resp_pend && resp_is_read) begin
            if (resp_owner) exp_drdata = resp_data;
            else exp_irdata = resp_data;
         end
         resp_pend = 1'b0;
         chk("i_resp", i_resp, exp_iresp);
         chk("d_resp", d_resp, exp_dresp);
         chk("i_rdata", i_rdata, exp_irdata);
         chk("d_rdata", d_rdata, exp_drdata);
         resp_seen = exp_iresp | exp_dresp;
         if (i_resp) i_read = 1'b0;
         if (d_resp) begin
            d_read  = 1'b0;
            d_write = 1'b0;
         end
      end
      if (mem_auto) mem_step();
   endtask

   task automatic run_until_idle(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (!i_read && !d_read && !d_write && tb_idle) return;
         tick();
      end
      chk("drain_timeout", 1, 0);
   endtask

   typedef struct {
      bit           i_en;
      logic [31:0]  i_a;
      bit           d_en;
      bit           d_wr;
      logic [31:0]  d_a;
      logic [255:0] d_wd;
      logic [255:0] fill;
      int           rl;
      int           wl;
      int           n;
      bit [1:0]     seq;          // bit k = owner of k-th grant, 1 = dcache
      logic [31:0]  first_addr;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b1, 32'h1ECEB004, 1'b0, 1'b0, 32'h0, 256'h0, {32{8'hA5}}, 2, 3, 1, 2'b00, 32'h1ECEB000};
      vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h00001040, 256'h1234, 256'h0, 0, 1, 1, 2'b01, 32'h00001040};
      vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h00001047, 256'h0, 256'h0, 1, 1, 1, 2'b01, 32'h00001040};
      vecs[3] = '{1'b1, 32'h10000020, 1'b1, 1'b0, 32'h20000000, 256'h0, {8{32'hCAFE0001}}, 0, 1, 2, 2'b10, 32'h10000020};
      vecs[4] = '{1'b1, 32'h1ABCDEFF, 1'b1, 1'b0, 32'h20000100, 256'h0, {8{32'h0BADF00D}}, 1, 2, 2, 2'b10, 32'h1ABCDEE0};
      vecs[5] = '{1'b1, 32'h10000040, 1'b0, 1'b0, 32'h0, 256'h0, {16{16'h3C69}}, 0, 1, 1, 2'b00, 32'h10000040};
      vecs[6] = '{1'b1, 32'h10000060, 1'b1, 1'b1, 32'h2000021F, 256'hDEAD_BEEF, {8{32'h76543210}}, 2, 1, 2, 2'b01, 32'h20000200};
      vecs[7] = '{1'b1, 32'h1FFFFFFF, 1'b0, 1'b0, 32'h0, 256'h0, {8{32'h13572468}}, 10, 2, 1, 2'b00, 32'h1FFFFFE0};

      rst       = 1'b1;
      i_addr    = '0;
      i_read    = 1'b0;
      d_addr    = '0;
      d_read    = 1'b0;
      d_write   = 1'b0;
      d_wdata   = '0;
      mem_ready = 1'b0;
      mem_resp  = 1'b0;
      mem_rdata = '0;
      mem_auto  = 1'b1;
      noise     = 1'b0;
      ready_lat = 0;
      resp_lat  = 1;
      n_accept  = 0;

      // reset with a pending icache read, then release
      req_i(32'h12345677);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_release_read", mem_read, 1);
      chk("rst_release_addr", mem_addr, 32'h12345660);
      run_until_idle(50);

      // reset while a read sits in WAIT, then a late mem_resp
      mem_auto = 1'b0;
      req_i(32'h10001000);
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      rst    = 1'b1;
      i_read = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      mem_rdata = rnd_line();
      mem_resp  = 1'b1;
      tick();
      mem_resp = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("midwait_no_resp", {i_resp, d_resp}, 0);
      end
      mem_auto = 1'b1;
      req_d(32'h20000040, 1'b0, '0);
      tick();
      chk("idle_after_reset", mem_read, 1);
      run_until_idle(50);

      for (int v = 0; v < 8; v++) begin
         int acc0;
         addr_log.delete();
         acc0      = n_accept;
         ready_lat = vecs[v].rl;
         resp_lat  = vecs[v].wl;
         if (vecs[v].i_en) begin
            mem_model[align(vecs[v].i_a)] = vecs[v].fill;
            req_i(vecs[v].i_a);
         end
         if (vecs[v].d_en) req_d(vecs[v].d_a, vecs[v].d_wr, vecs[v].d_wd);
         run_until_idle(200);
         chk($sformatf("vec%0d_grants", v), addr_log.size(), vecs[v].n);
         chk($sformatf("vec%0d_accepts", v), n_accept - acc0, vecs[v].n);
         if (addr_log.size() > 0) chk($sformatf("vec%0d_first_addr", v), addr_log[0], vecs[v].first_addr);
         for (int k = 0; k < vecs[v].n && k < addr_log.size(); k++) begin
            logic [31:0] a;
            a = addr_log[k];
            chk($sformatf("vec%0d_owner%0d", v, k), !a[28], vecs[v].seq[k]);
         end
      end

      // random traffic with spurious memory strobes and inputs changing mid-flight
      noise = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!(mem_read || mem_write) && !awaiting) begin
            ready_lat = $urandom_range(0, 3);
            resp_lat  = $urandom_range(1, 4);
         end
         if (!i_read) begin
            if ($urandom_range(0, 2) == 0) req_i({4'h1, 28'($urandom)});
            else i_addr = $urandom;
         end
         if (!d_read && !d_write) begin
            if ($urandom_range(0, 2) == 0)
               req_d({4'h2, 19'h0, 4'($urandom_range(0, 15)), 5'($urandom)}, 1'($urandom), rnd_line());
            else begin
               d_addr  = $urandom;
               d_wdata = rnd_line();
            end
         end
         tick();
      end
      noise = 1'b0;
      run_until_idle(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
